// File: rtl/jk_ctrl_pkg.sv
// Shared encodings for the JK counter controller: command ops, FSM states and
// per-cell J/K drive pairs, packed as {j, k}.
package jk_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_CLEAR = 2'b00,
      OP_LOAD  = 2'b01,
      OP_UP    = 2'b10,
      OP_DOWN  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_CLR  = 2'b01;
   localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-low reset to 0.
module jk_cell (
   input  logic clk,
   input  logic reset,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            2'b00:   q <= q;
            2'b10:   q <= 1'b1;
            2'b01:   q <= 1'b0;
            default: q <= ~q;
         endcase
      end
   end

endmodule

// File: rtl/jk_counter_ctrl.sv
// Command sequencer driving a WIDTH-bit array of JK cells: clear, load, or count
// up/down for a latched number of steps, with done and wrap pulses.
module jk_counter_ctrl
   import jk_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned LEN_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [LEN_W-1:0] cmd_len,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done,
   output logic             wrap
);

   state_e           state_q;
   op_e              op_q;
   logic [WIDTH-1:0] data_q;
   logic [LEN_W-1:0] cnt_q;
   logic             done_q;
   logic             wrap_q;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         op_q    <= OP_CLEAR;
         data_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         wrap_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_q    <= op_e'(cmd_op);
                  data_q  <= cmd_data;
                  // Only UP/DOWN (op msb set) use the run length; zero means one step.
                  if (cmd_op[1] && (cmd_len != '0)) cnt_q <= cmd_len;
                  else                              cnt_q <= LEN_W'(1);
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               cnt_q  <= cnt_q - LEN_W'(1);
               wrap_q <= ((op_q == OP_UP) && (&q)) || ((op_q == OP_DOWN) && !(|q));
               if (cnt_q == LEN_W'(1)) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Ripple the "all lower bits ones/zeros" condition from bit 0 upward.
   always_comb begin
      logic       all_ones;
      logic       all_zeros;
      logic [1:0] drv;
      all_ones  = 1'b1;
      all_zeros = 1'b1;
      drv       = JK_HOLD;
      j         = '0;
      k         = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         drv = JK_HOLD;
         if (state_q == S_RUN) begin
            case (op_q)
               OP_CLEAR: drv = JK_CLR;
               OP_LOAD:  drv = data_q[i] ? JK_SET : JK_CLR;
               OP_UP:    drv = all_ones ? JK_TGL : JK_HOLD;
               OP_DOWN:  drv = all_zeros ? JK_TGL : JK_HOLD;
               default:  drv = JK_HOLD;
            endcase
         end
         j[i]      = drv[1];
         k[i]      = drv[0];
         all_ones  = all_ones & q[i];
         all_zeros = all_zeros & ~q[i];
      end
   end

   for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_cell
      jk_cell u_cell (
         .clk   (clk),
         .reset (reset),
         .j     (j[gi]),
         .k     (k[gi]),
         .q     (q[gi])
      );
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Randomised and directed bench for jk_counter_ctrl against an integer counter model.
module tb_jk_counter_ctrl;
   import jk_ctrl_pkg::*;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned LEN_W = 8;
   localparam int          MOD   = 1 << WIDTH;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [1:0]       cmd_op = 2'b00;
   logic [WIDTH-1:0] cmd_data = '0;
   logic [LEN_W-1:0] cmd_len = '0;
   logic [WIDTH-1:0] q;
   logic             busy;
   logic             done;
   logic             wrap;

   int checks = 0;
   int errors = 0;
   int model_q = 0;

   always #5 clk = ~clk;

   jk_counter_ctrl #(
      .WIDTH (WIDTH),
      .LEN_W (LEN_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_len   (cmd_len),
      .q         (q),
      .busy      (busy),
      .done      (done),
      .wrap      (wrap)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one command from IDLE and check every cycle until the controller is idle again.
   task automatic run_cmd(input logic [1:0] op, input logic [WIDTH-1:0] data,
                          input logic [LEN_W-1:0] len, input bit hold_load,
                          input logic [WIDTH-1:0] next_data);
      int steps;
      int waited;
      int prev;
      bit wrapped;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_len   = len;
      waited    = 0;
      while (!cmd_ready && waited < 64) begin
         @(negedge clk);
         waited++;
      end
      if (!cmd_ready) begin
         check("ready_timeout", 32'(cmd_ready), 32'd1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      check("accept_busy", 32'(busy), 32'd1);
      check("accept_ready", 32'(cmd_ready), 32'd0);
      check("accept_q", 32'(q), 32'(model_q));
      steps = op[1] ? ((len == '0) ? 1 : int'(len)) : 1;
      for (int s = 1; s <= steps; s++) begin
         if (hold_load) begin
            cmd_valid = 1'b1;
            cmd_op    = OP_LOAD;
            cmd_data  = next_data;
            cmd_len   = LEN_W'($urandom);
         end else begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 2'($urandom);
            cmd_data  = WIDTH'($urandom);
            cmd_len   = LEN_W'($urandom);
         end
         @(posedge clk);
         @(negedge clk);
         prev    = model_q;
         wrapped = 1'b0;
         case (op)
            2'b00: model_q = 0;
            2'b01: model_q = int'(data);
            2'b10: begin
               model_q = (prev + 1) % MOD;
               wrapped = (prev == MOD - 1);
            end
            default: begin
               model_q = (prev + MOD - 1) % MOD;
               wrapped = (prev == 0);
            end
         endcase
         check("run_q", 32'(q), 32'(model_q));
         check("run_wrap", 32'(wrap), 32'(wrapped));
         check("run_done", 32'(done), 32'(s == steps));
         check("run_busy", 32'(busy), 32'd1);
         check("run_ready", 32'(cmd_ready), 32'd0);
      end
      if (!hold_load) cmd_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_ready", 32'(cmd_ready), 32'd1);
      check("idle_done", 32'(done), 32'd0);
      check("idle_wrap", 32'(wrap), 32'd0);
      check("idle_q", 32'(q), 32'(model_q));
   endtask

   initial begin
      // Reset held with a pending command: nothing may be accepted.
      cmd_valid = 1'b1;
      cmd_op    = OP_LOAD;
      cmd_data  = 4'h5;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         check("rst_q", 32'(q), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_done", 32'(done), 32'd0);
         check("rst_wrap", 32'(wrap), 32'd0);
         check("rst_ready", 32'(cmd_ready), 32'd1);
      end
      reset   = 1'b1;
      model_q = 0;
      run_cmd(OP_LOAD, 4'h5, 8'd0, 1'b0, 4'h0);

      run_cmd(OP_LOAD, 4'hA, 8'd0, 1'b0, 4'h0);
      run_cmd(OP_UP, 4'h0, 8'd3, 1'b0, 4'h0);
      run_cmd(OP_LOAD, 4'hE, 8'd0, 1'b0, 4'h0);
      run_cmd(OP_UP, 4'h0, 8'd2, 1'b0, 4'h0);
      run_cmd(OP_DOWN, 4'h0, 8'd0, 1'b0, 4'h0);
      run_cmd(OP_CLEAR, 4'h7, 8'd9, 1'b0, 4'h0);

      // LOAD held valid during an UP run must only be taken once ready returns.
      run_cmd(OP_UP, 4'h0, 8'd10, 1'b1, 4'h3);
      check("hold_q", 32'(q), 32'hA);
      run_cmd(OP_LOAD, 4'h3, 8'd0, 1'b0, 4'h0);
      run_cmd(OP_CLEAR, 4'h0, 8'd0, 1'b0, 4'h0);

      // Abort an UP run with reset after three count edges.
      cmd_valid = 1'b1;
      cmd_op    = OP_UP;
      cmd_len   = 8'd10;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("abort_pre_q", 32'(q), 32'(model_q + 3));
      reset = 1'b0;
      #1;
      check("abort_q", 32'(q), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ready", 32'(cmd_ready), 32'd1);
      check("abort_done", 32'(done), 32'd0);
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         check("abort_no_done", 32'(done), 32'd0);
      end
      reset   = 1'b1;
      model_q = 0;
      run_cmd(OP_DOWN, 4'h0, 8'd2, 1'b0, 4'h0);

      run_cmd(OP_UP, 4'h0, 8'hFF, 1'b0, 4'h0);
      for (int n = 0; n < 40; n++) begin
         run_cmd(2'($urandom), WIDTH'($urandom), LEN_W'($urandom_range(0, 20)), 1'b0, 4'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
